// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: walks each instruction through
// fetch/decode/execute/memory/writeback states over a shared memory and ALU.
module multicycle_ctrl #(
    parameter bit          MEM_HANDSHAKE  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic [2:0] imm_sel,
    output logic       instr_retired,
    output logic       trap,
    output logic [3:0] state
);

    localparam int unsigned CNT_W = 8;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_UPPER    = 4'd13,
        S_TRAP     = 4'd15
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;

    logic       w_ready;
    logic       w_mem_state;
    logic       w_wait;
    logic       w_timeout;

    logic       w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_reg_write;
    logic [1:0] w_src_a, w_src_b, w_alu_op, w_result_src;
    logic [2:0] w_imm_sel;
    logic       w_retired, w_trap;

    // Handshake can be disabled at build time for single-cycle memories.
    assign w_ready     = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    assign w_wait      = w_mem_state && !w_ready;
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && w_wait
                         && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_wait && !w_timeout) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_src_a      = 2'b00;
        w_src_b      = 2'b00;
        w_alu_op     = 2'b00;
        w_result_src = 2'b00;
        w_imm_sel    = 3'b000;
        w_retired    = 1'b0;
        w_trap       = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_src_b      = 2'b10;
                w_result_src = 2'b10;
                if (w_timeout) begin
                    w_next = S_TRAP;
                end else if (w_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here; JAL needs the J immediate.
                w_src_a   = 2'b01;
                w_src_b   = 2'b01;
                w_imm_sel = (op == OP_JAL) ? 3'b100 : 3'b010;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI, OP_AUIPC:  w_next = S_UPPER;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_src_a   = 2'b10;
                w_src_b   = 2'b01;
                w_imm_sel = op[5] ? 3'b001 : 3'b000;
                w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (w_timeout) begin
                    w_next = S_TRAP;
                end else if (w_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_retired    = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (w_timeout) begin
                    w_next = S_TRAP;
                end else if (w_ready) begin
                    w_retired = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_EXECR: begin
                w_src_a  = 2'b10;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_EXECI: begin
                w_src_a  = 2'b10;
                w_src_b  = 2'b01;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retired   = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_src_a    = 2'b10;
                w_alu_op   = 2'b01;
                w_pc_write = branch_taken;
                w_retired  = 1'b1;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                // Jump to precomputed target while ALU forms the link value.
                w_src_a    = 2'b01;
                w_src_b    = 2'b10;
                w_imm_sel  = 3'b100;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
            S_JALR: begin
                w_src_a      = 2'b10;
                w_src_b      = 2'b01;
                w_result_src = 2'b10;
                w_pc_write   = 1'b1;
                w_next       = S_LINK;
            end
            S_LINK: begin
                w_src_a      = 2'b01;
                w_src_b      = 2'b10;
                w_result_src = 2'b10;
                w_reg_write  = 1'b1;
                w_retired    = 1'b1;
                w_next       = S_FETCH;
            end
            S_UPPER: begin
                w_src_a   = 2'b01;
                w_src_b   = 2'b01;
                w_imm_sel = 3'b011;
                w_alu_op  = op[5] ? 2'b11 : 2'b00;
                w_next    = S_ALUWB;
            end
            S_TRAP: begin
                w_trap = 1'b1;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase
    end

    // Reset forces every output low immediately, including mid-access.
    assign mem_req       = w_mem_req    & ~rst;
    assign MemWrite      = w_mem_write  & ~rst;
    assign AdrSrc        = w_adr_src    & ~rst;
    assign IRWrite       = w_ir_write   & ~rst;
    assign PCWrite       = w_pc_write   & ~rst;
    assign RegWrite      = w_reg_write  & ~rst;
    assign ALUSrcA       = rst ? 2'b00  : w_src_a;
    assign ALUSrcB       = rst ? 2'b00  : w_src_b;
    assign ALUOp         = rst ? 2'b00  : w_alu_op;
    assign ResultSrc     = rst ? 2'b00  : w_result_src;
    assign imm_sel       = rst ? 3'b000 : w_imm_sel;
    assign instr_retired = w_retired    & ~rst;
    assign trap          = w_trap       & ~rst;
    assign state         = rst ? 4'd0   : r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl; control vectors are
// hand-computed per state and compared every cycle.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [2:0] imm_sel;
    logic       instr_retired, trap;
    logic [3:0] state;

    multicycle_ctrl #(
        .MEM_HANDSHAKE (1'b1),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op           (op),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .MemWrite     (MemWrite),
        .AdrSrc       (AdrSrc),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .RegWrite     (RegWrite),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOp        (ALUOp),
        .ResultSrc    (ResultSrc),
        .imm_sel      (imm_sel),
        .instr_retired(instr_retired),
        .trap         (trap),
        .state        (state)
    );

    logic [22:0] got;
    assign got = {state, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, imm_sel, instr_retired, trap};

    typedef struct {
        logic        r;
        logic [6:0]  o;
        logic        bt;
        logic        rdy;
        logic [22:0] e;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_err    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // en = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite}
    function automatic logic [22:0] ex(input logic [3:0] s, input logic [5:0] en,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] aop, input logic [1:0] rs,
                                       input logic [2:0] imm, input logic ret,
                                       input logic trp);
        return {s, en, sa, sb, aop, rs, imm, ret, trp};
    endfunction

    task automatic add(input logic r, input logic [6:0] o, input logic bt,
                       input logic rdy, input logic [22:0] e);
        vec_t v;
        v.r = r; v.o = o; v.bt = bt; v.rdy = rdy; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [22:0] e);
        n_checks++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                     name, got, e, got[22:19], e[22:19]);
        end
    endtask

    task automatic step(input logic r, input logic [6:0] o, input logic bt, input logic rdy);
        @(negedge clk);
        rst = r; op = o; branch_taken = bt; mem_ready = rdy;
        #1;
    endtask

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111,
                           BAD = 7'b1111111;

    logic [22:0] ZERO, F_RDY, F_WAIT, DEC_B, DEC_J, MA_L, MA_S, MR, MWB, MW_W, MW_R;
    logic [22:0] EXR, EXI, AWB, BR_T, BR_N, JAL_S, JALR_S, LINK_S, LUI_S, AUI_S, TRP;

    initial begin
        ZERO   = '0;
        F_RDY  = ex(4'd0,  6'b100110, 2'd0, 2'd2, 2'd0, 2'd2, 3'd0, 1'b0, 1'b0);
        F_WAIT = ex(4'd0,  6'b100000, 2'd0, 2'd2, 2'd0, 2'd2, 3'd0, 1'b0, 1'b0);
        DEC_B  = ex(4'd1,  6'b000000, 2'd1, 2'd1, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0);
        DEC_J  = ex(4'd1,  6'b000000, 2'd1, 2'd1, 2'd0, 2'd0, 3'd4, 1'b0, 1'b0);
        MA_L   = ex(4'd2,  6'b000000, 2'd2, 2'd1, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        MA_S   = ex(4'd2,  6'b000000, 2'd2, 2'd1, 2'd0, 2'd0, 3'd1, 1'b0, 1'b0);
        MR     = ex(4'd3,  6'b101000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        MWB    = ex(4'd4,  6'b000001, 2'd0, 2'd0, 2'd0, 2'd1, 3'd0, 1'b1, 1'b0);
        MW_W   = ex(4'd5,  6'b111000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        MW_R   = ex(4'd5,  6'b111000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0);
        EXR    = ex(4'd6,  6'b000000, 2'd2, 2'd0, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0);
        EXI    = ex(4'd8,  6'b000000, 2'd2, 2'd1, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0);
        AWB    = ex(4'd7,  6'b000001, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0);
        BR_T   = ex(4'd10, 6'b000010, 2'd2, 2'd0, 2'd1, 2'd0, 3'd0, 1'b1, 1'b0);
        BR_N   = ex(4'd10, 6'b000000, 2'd2, 2'd0, 2'd1, 2'd0, 3'd0, 1'b1, 1'b0);
        JAL_S  = ex(4'd9,  6'b000010, 2'd1, 2'd2, 2'd0, 2'd0, 3'd4, 1'b0, 1'b0);
        JALR_S = ex(4'd11, 6'b000010, 2'd2, 2'd1, 2'd0, 2'd2, 3'd0, 1'b0, 1'b0);
        LINK_S = ex(4'd12, 6'b000001, 2'd1, 2'd2, 2'd0, 2'd2, 3'd0, 1'b1, 1'b0);
        LUI_S  = ex(4'd13, 6'b000000, 2'd1, 2'd1, 2'd3, 2'd0, 3'd3, 1'b0, 1'b0);
        AUI_S  = ex(4'd13, 6'b000000, 2'd1, 2'd1, 2'd0, 2'd0, 3'd3, 1'b0, 1'b0);
        TRP    = ex(4'd15, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);

        rst = 1'b1; op = '0; branch_taken = 1'b0; mem_ready = 1'b0;

        // reset, then ADDI with memory always ready
        add(1, IT, 0, 1, ZERO);
        add(1, IT, 1, 1, ZERO);
        add(0, IT, 0, 1, F_RDY); add(0, IT, 0, 1, DEC_B); add(0, IT, 0, 1, EXI); add(0, IT, 0, 1, AWB);
        // LW: 3 wait cycles in fetch, 2 in memread
        add(0, LW, 0, 0, F_WAIT); add(0, LW, 0, 0, F_WAIT); add(0, LW, 0, 0, F_WAIT);
        add(0, LW, 0, 1, F_RDY);  add(0, LW, 0, 1, DEC_B);  add(0, LW, 0, 1, MA_L);
        add(0, LW, 0, 0, MR);     add(0, LW, 0, 0, MR);     add(0, LW, 0, 1, MR);
        add(0, LW, 0, 1, MWB);
        // SW ready immediately
        add(0, SW, 0, 1, F_RDY); add(0, SW, 0, 1, DEC_B); add(0, SW, 0, 1, MA_S); add(0, SW, 0, 1, MW_R);
        // BEQ taken / not taken
        add(0, BR, 1, 1, F_RDY); add(0, BR, 1, 1, DEC_B); add(0, BR, 1, 1, BR_T);
        add(0, BR, 0, 1, F_RDY); add(0, BR, 0, 1, DEC_B); add(0, BR, 0, 1, BR_N);
        // JAL, JALR, LUI, AUIPC, R-type
        add(0, JL, 0, 1, F_RDY); add(0, JL, 0, 1, DEC_J); add(0, JL, 0, 1, JAL_S);  add(0, JL, 0, 1, AWB);
        add(0, JR, 0, 1, F_RDY); add(0, JR, 0, 1, DEC_B); add(0, JR, 0, 1, JALR_S); add(0, JR, 0, 1, LINK_S);
        add(0, LU, 0, 1, F_RDY); add(0, LU, 0, 1, DEC_B); add(0, LU, 0, 1, LUI_S);  add(0, LU, 0, 1, AWB);
        add(0, AU, 0, 1, F_RDY); add(0, AU, 0, 1, DEC_B); add(0, AU, 0, 1, AUI_S);  add(0, AU, 0, 1, AWB);
        add(0, RT, 0, 1, F_RDY); add(0, RT, 0, 1, DEC_B); add(0, RT, 0, 1, EXR);    add(0, RT, 0, 1, AWB);
        add(0, IT, 0, 1, F_RDY);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].o, tbl[i].bt, tbl[i].rdy);
            check($sformatf("vec%0d", i), tbl[i].e);
        end

        // illegal opcode traps and stays trapped whatever the inputs do
        step(0, BAD, 1, 1); check("illegal_decode", DEC_B);
        for (int k = 0; k < 20; k++) begin
            step(0, BAD, 1, 1); check($sformatf("trap_hold%0d", k), TRP);
        end
        step(1, BAD, 1, 1); check("trap_rst", ZERO);
        step(0, SW, 0, 1);  check("after_trap_fetch", F_RDY);

        // store whose memory never answers: four wait cycles then trap
        step(0, SW, 0, 1); check("to_decode", DEC_B);
        step(0, SW, 0, 0); check("to_memadr", MA_S);
        for (int k = 0; k < 4; k++) begin
            step(0, SW, 0, 0); check($sformatf("to_wait%0d", k), MW_W);
        end
        step(0, SW, 0, 0); check("to_trap", TRP);
        step(0, SW, 0, 0); check("to_trap_sticky", TRP);

        // reset dropped in the middle of a store wait
        step(1, SW, 0, 1); check("rst_in_trap", ZERO);
        step(0, SW, 0, 1); check("mw_fetch", F_RDY);
        step(0, SW, 0, 1); check("mw_decode", DEC_B);
        step(0, SW, 0, 0); check("mw_memadr", MA_S);
        step(0, SW, 0, 0); check("mw_wait", MW_W);
        #1 rst = 1'b1;
        #1 check("async_rst", ZERO);
        step(1, SW, 0, 0); check("rst_held", ZERO);
        step(0, SW, 0, 0); check("rst_release_fetch", F_WAIT);
        step(0, SW, 0, 1); check("rst_release_ready", F_RDY);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
